// File: rtl/vx_cache_perf_agg.sv
// Multi-bank cache performance-counter aggregator.
// Per-bank event strobes are population-counted, registered (stage 1), and
// added into one CTR_WIDTH counter per event (stage 2). A four-phase
// snap_req/snap_ack handshake freezes a coherent copy of all counters.
// Build option: define PERF_PREFETCH_CTRS_EN to add the three prefetch
// events (NUM_EVT = 11); otherwise NUM_EVT = 8.
module vx_cache_perf_agg #(
  parameter int unsigned NUM_BANKS     = 4,
  parameter int unsigned CTR_WIDTH     = 44,
  parameter int unsigned SATURATE      = 0,
  parameter int unsigned CLEAR_ON_SNAP = 0,
`ifdef PERF_PREFETCH_CTRS_EN
  localparam int unsigned NUM_EVT      = 11
`else
  localparam int unsigned NUM_EVT      = 8
`endif
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           clear,
  input  logic [NUM_EVT*NUM_BANKS-1:0]   events,
  output logic [NUM_EVT*CTR_WIDTH-1:0]   ctr_live,
  output logic [NUM_EVT-1:0]             ovf,
  input  logic                           snap_req,
  output logic                           snap_ack,
  output logic [NUM_EVT*CTR_WIDTH-1:0]   snap_data
);

  localparam int unsigned IW = $clog2(NUM_BANKS + 1);

  typedef enum logic {StIdle, StHold} snap_state_e;

  snap_state_e          state_q;
  logic [IW-1:0]        inc_d  [NUM_EVT];
  logic [IW-1:0]        inc_q  [NUM_EVT];
  logic [CTR_WIDTH-1:0] ctr_d  [NUM_EVT];
  logic [CTR_WIDTH-1:0] ctr_q  [NUM_EVT];
  logic [CTR_WIDTH-1:0] snap_q [NUM_EVT];
  logic [NUM_EVT-1:0]   ovf_d;
  logic [NUM_EVT-1:0]   ovf_q;
  logic                 capture;

  // A capture edge is any edge seen in IDLE with the request raised.
  assign capture = (state_q == StIdle) && snap_req;

  // Population count of each event's bank strobes.
  always_comb begin
    for (int e = 0; e < NUM_EVT; e++) begin
      inc_d[e] = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        inc_d[e] = inc_d[e] + IW'(events[e*NUM_BANKS+b]);
      end
    end
  end

  // Stage 1: enable gates only this capture; clear flushes pending increments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < NUM_EVT; e++) inc_q[e] <= '0;
    end else begin
      for (int e = 0; e < NUM_EVT; e++) begin
        if (clear || !enable) inc_q[e] <= '0;
        else                  inc_q[e] <= inc_d[e];
      end
    end
  end

  // Stage 2 next state: clear beats snapshot-clear beats the normal add.
  always_comb begin
    logic [CTR_WIDTH:0] sum;
    sum   = '0;
    ovf_d = ovf_q;
    for (int e = 0; e < NUM_EVT; e++) begin
      sum      = {1'b0, ctr_q[e]} + (CTR_WIDTH+1)'(inc_q[e]);
      ctr_d[e] = ctr_q[e];
      if (clear) begin
        ctr_d[e] = '0;
        ovf_d[e] = 1'b0;
      end else if (capture && (CLEAR_ON_SNAP != 0)) begin
        // Restart from the pending increment so no event is lost.
        ctr_d[e] = CTR_WIDTH'(inc_q[e]);
        ovf_d[e] = 1'b0;
      end else if (sum[CTR_WIDTH]) begin
        if (SATURATE != 0) begin
          ctr_d[e] = '1;
        end else begin
          ctr_d[e] = sum[CTR_WIDTH-1:0];
          ovf_d[e] = 1'b1;
        end
      end else begin
        ctr_d[e] = sum[CTR_WIDTH-1:0];
      end
    end
  end

  // Counter and sticky overflow registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < NUM_EVT; e++) ctr_q[e] <= '0;
      ovf_q <= '0;
    end else begin
      for (int e = 0; e < NUM_EVT; e++) ctr_q[e] <= ctr_d[e];
      ovf_q <= ovf_d;
    end
  end

  // Snapshot FSM with registered ack; snap_data takes the pre-add, pre-clear values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      snap_ack <= 1'b0;
      for (int e = 0; e < NUM_EVT; e++) snap_q[e] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (snap_req) begin
            state_q  <= StHold;
            snap_ack <= 1'b1;
            for (int e = 0; e < NUM_EVT; e++) snap_q[e] <= ctr_q[e];
          end
        end
        StHold: begin
          if (!snap_req) begin
            state_q  <= StIdle;
            snap_ack <= 1'b0;
          end
        end
        default: begin
          state_q  <= StIdle;
          snap_ack <= 1'b0;
        end
      endcase
    end
  end

  // Flatten internal arrays onto the packed output buses.
  for (genvar g = 0; g < NUM_EVT; g++) begin : g_pack
    assign ctr_live[g*CTR_WIDTH +: CTR_WIDTH]  = ctr_q[g];
    assign snap_data[g*CTR_WIDTH +: CTR_WIDTH] = snap_q[g];
  end

  assign ovf = ovf_q;

endmodule

// File: tb/tb_vx_cache_perf_agg.sv
// Self-checking bench for vx_cache_perf_agg. Two instances with 8-bit counters
// share stimulus: one wraps (SATURATE=0), one saturates and clears on snapshot.
// Both are compared every cycle against an arithmetic reference model.
module tb_vx_cache_perf_agg;

`ifdef PERF_PREFETCH_CTRS_EN
  localparam int NE = 11;
`else
  localparam int NE = 8;
`endif
  localparam int NB   = 4;
  localparam int CW   = 8;
  localparam int MAXV = 255;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               enable;
  logic               clear;
  logic [NE*NB-1:0]   events;
  logic               snap_req;
  logic [NE*CW-1:0]   ctr_live_w, ctr_live_s, snap_data_w, snap_data_s;
  logic [NE-1:0]      ovf_w, ovf_s;
  logic               snap_ack_w, snap_ack_s;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int unsigned m_ctr  [2][NE];
  int unsigned m_snap [2][NE];
  bit          m_ovf  [2][NE];
  int unsigned m_pend [NE];
  bit          m_hold;

  bit               cur_req;
  logic [NE*NB-1:0] ev_v;
  logic [63:0]      rnd;

  always #5 clk = ~clk;

  vx_cache_perf_agg #(
    .NUM_BANKS(NB), .CTR_WIDTH(CW), .SATURATE(0), .CLEAR_ON_SNAP(0)
  ) dut_wrap (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .events(events),
    .ctr_live(ctr_live_w), .ovf(ovf_w), .snap_req(snap_req), .snap_ack(snap_ack_w),
    .snap_data(snap_data_w)
  );

  vx_cache_perf_agg #(
    .NUM_BANKS(NB), .CTR_WIDTH(CW), .SATURATE(1), .CLEAR_ON_SNAP(1)
  ) dut_sat (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .events(events),
    .ctr_live(ctr_live_s), .ovf(ovf_s), .snap_req(snap_req), .snap_ack(snap_ack_s),
    .snap_data(snap_data_s)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] pk(input int c, input bit snap);
    logic [127:0] r;
    r = '0;
    for (int e = 0; e < NE; e++) r[e*CW +: CW] = CW'(snap ? m_snap[c][e] : m_ctr[c][e]);
    return r;
  endfunction

  function automatic logic [127:0] pk_ovf(input int c);
    logic [127:0] r;
    r = '0;
    for (int e = 0; e < NE; e++) r[e] = m_ovf[c][e];
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int e = 0; e < NE; e++) begin
        m_ctr[c][e] = 0; m_snap[c][e] = 0; m_ovf[c][e] = 0;
      end
    for (int e = 0; e < NE; e++) m_pend[e] = 0;
    m_hold = 0;
  endtask

  task automatic compare_all();
    chk("ctr_live_wrap",  ctr_live_w,  pk(0, 0));
    chk("ctr_live_sat",   ctr_live_s,  pk(1, 0));
    chk("ovf_wrap",       ovf_w,       pk_ovf(0));
    chk("ovf_sat",        ovf_s,       pk_ovf(1));
    chk("snap_ack_wrap",  snap_ack_w,  m_hold);
    chk("snap_ack_sat",   snap_ack_s,  m_hold);
    chk("snap_data_wrap", snap_data_w, pk(0, 1));
    chk("snap_data_sat",  snap_data_s, pk(1, 1));
  endtask

  // Called at a negedge: check outputs, drive inputs, advance model by one edge.
  task automatic step(input bit en, input bit clr, input logic [NE*NB-1:0] ev, input bit req);
    bit          cap;
    int unsigned s;
    compare_all();
    enable   = en;
    clear    = clr;
    events   = ev;
    snap_req = req;
    cap = !m_hold && req;
    for (int c = 0; c < 2; c++) begin
      for (int e = 0; e < NE; e++) begin
        if (cap) m_snap[c][e] = m_ctr[c][e];
        if (clr) begin
          m_ctr[c][e] = 0; m_ovf[c][e] = 0;
        end else if (cap && c == 1) begin
          m_ctr[c][e] = m_pend[e]; m_ovf[c][e] = 0;
        end else begin
          s = m_ctr[c][e] + m_pend[e];
          if (s > MAXV) begin
            if (c == 1) m_ctr[c][e] = MAXV;
            else begin
              m_ctr[c][e] = s - (MAXV + 1); m_ovf[c][e] = 1;
            end
          end else m_ctr[c][e] = s;
        end
      end
    end
    if (cap) m_hold = 1;
    else if (m_hold && !req) m_hold = 0;
    for (int e = 0; e < NE; e++)
      m_pend[e] = (clr || !en) ? 0 : $countones(ev[e*NB +: NB]);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; clear = 1'b0; events = '0; snap_req = 1'b0;
    cur_req = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ctr_live", ctr_live_w, '0);
    chk("rst_snap_ack", snap_ack_s, '0);
    chk("rst_ovf",      ovf_w,      '0);
    reset_n = 1'b1;

    // Single-cycle strobe on event 0, banks 0,1,3.
    ev_v = '0;
    ev_v[3:0] = 4'b1011;
    step(1, 0, ev_v, 0);
    step(1, 0, '0, 0);
    chk("t1_ctr0", ctr_live_w[CW-1:0], 3);

    // Dense strobes without snapshots: exercises wrap and saturation.
    for (int i = 0; i < 500; i++) begin
      rnd = {$urandom, $urandom} | {$urandom, $urandom};
      step(($urandom % 10) != 0, 0, rnd[NE*NB-1:0], 0);
    end

    // Mixed traffic with clears and four-phase snapshot handshakes.
    for (int i = 0; i < 1000; i++) begin
      if (cur_req && m_hold && ($urandom % 4 == 0)) cur_req = 1'b0;
      else if (!cur_req && !m_hold && ($urandom % 8 == 0)) cur_req = 1'b1;
      rnd = {$urandom, $urandom} & {$urandom, $urandom} | {$urandom, $urandom};
      step(($urandom % 8) != 0, ($urandom % 100) == 0, rnd[NE*NB-1:0], cur_req);
    end
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);

    // Async reset in HOLD drops ack and counters before any clock edge.
    step(1, 0, '1, 1);
    step(1, 0, '1, 1);
    chk("t6_ack_before_rst", snap_ack_w, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_ack",  snap_ack_w, 0);
    chk("t6_rst_ctr",  ctr_live_s, '0);
    chk("t6_rst_snap", snap_data_w, '0);
    @(negedge clk);
    snap_req = 1'b0;
    reset_n  = 1'b1;
    model_reset();
    step(1, 1, '1, 0);
    step(1, 0, '0, 0);
    chk("t6_clear_wins", ctr_live_w, '0);
    step(1, 0, '0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
